// File: rtl/regdump_tx.sv
//------------------------------------------------------------------------------
// regdump_tx
//   Serialises a four-entry register file over an 8N1 UART-style line.
//   A dump sends HEADER followed by r0..r3, back to back with no idle gap.
//   Each register is read once, at the edge that loads its frame.
//
// Ports
//   clock    in   1  single clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   start    in   1  request one dump (ignored while busy)
//   rd_addr  out  2  register-file read address (registered)
//   rd_data  in   8  register-file read data for rd_addr (combinational)
//   tx       out  1  serial line, idle high (registered)
//   busy     out  1  high while a dump is in progress
//   done     out  1  one-cycle pulse when a dump completes
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module regdump_tx #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;       // cycles within the current bit
  logic [2:0]    bit_q, bit_d;       // data bit index
  logic [2:0]    byte_q, byte_d;     // frames already loaded after HEADER
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    rd_addr_q, rd_addr_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          bit_end;

  assign bit_end = (cnt_q == BIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      rd_addr_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      rd_addr_q <= rd_addr_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + CW'(1);
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    rd_addr_d = rd_addr_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Hold the bit counter at zero so the first start bit is a full period.
        cnt_d = '0;
        if (start) begin
          state_d   = START;
          busy_d    = 1'b1;
          tx_d      = 1'b0;
          shift_d   = HEADER;
          byte_d    = '0;
          rd_addr_d = '0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          if (byte_q < 3'd4) begin
            // Snapshot the addressed register here; later writes cannot
            // disturb this frame. rd_addr wraps 3->0 after the last load.
            state_d   = START;
            shift_d   = rd_data;
            rd_addr_d = rd_addr_q + 2'd1;
            byte_d    = byte_q + 3'd1;
            tx_d      = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_addr = rd_addr_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: doc/regdump_tx.md
REGDUMP_TX -- requirements
Module: regdump_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter HEADER, default 8'hA5: sync byte sent before register contents.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one register dump; sampled on posedge clock.
REQ-006 rd_addr  output  2  register-file read address; registered output.
REQ-007 rd_data  input  8  register-file read data for rd_addr, combinational from the register file.
REQ-008 tx  output  1  serial line, idle high; registered output.
REQ-009 busy  output  1  high while a dump is in progress.
REQ-010 done  output  1  one-cycle pulse when a dump completes.

Function
REQ-011 A dump is exactly 5 frames in order: HEADER, then r0, r1, r2, r3.
REQ-012 Frame format: 8N1, i.e. start bit 0, 8 data bits LSB first, stop bit 1.
REQ-013 Each bit drives tx for exactly CLKS_PER_BIT cycles; one frame is 10*CLKS_PER_BIT cycles.
REQ-014 Frames are back-to-back with no idle gap; a full dump is 50*CLKS_PER_BIT cycles.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START at the edge sampling start=1, with the following effects at that edge: busy<=1, tx<=0, shift<=HEADER, byte_cnt<=0, rd_addr<=0.
REQ-017 START -> DATA after CLKS_PER_BIT cycles; DATA stays for 8 bit periods, shifting right once per period, with tx<=shift[0].
REQ-018 DATA -> STOP after the 8th data bit; tx<=1 for one bit period.
REQ-019 End of STOP with byte_cnt<4: shift<=rd_data (value at rd_addr in that cycle), rd_addr<=rd_addr+1 (wraps 3->0), byte_cnt+1, tx<=0, next state START.
REQ-020 End of STOP with byte_cnt==4: state IDLE, busy<=0, done<=1 for exactly one cycle, tx stays 1.
REQ-021 Each register value is snapshotted at the single edge that loads its frame; register writes after that edge do not affect the frame in flight.
REQ-022 start while busy=1 is ignored; no queuing.
REQ-023 start held high continuously: a new dump begins on the edge after done, i.e. in the cycle where IDLE is sampled with start=1.
REQ-024 done and busy are never high in the same cycle.
REQ-025 rd_addr changes only at reset, at dump start, and at frame loads.
REQ-026 Bit-period counter width is ceil(log2(CLKS_PER_BIT)); the counter resets to 0 at every bit boundary.

Reset
REQ-027 reset=1 forces immediately, without waiting for clock: state=IDLE, tx=1, busy=0, done=0, rd_addr=0, byte_cnt=0, shift=0, bit counters=0.
REQ-028 reset asserted mid-frame aborts the dump; no partial frame resumes after release.
REQ-029 The first start is accepted at the first posedge clock after reset deasserts.

Verification
REQ-030 CLKS_PER_BIT=4, registers r0..r3 = 11,22,33,44, pulse start -> tx decodes as A5,11,22,33,44; busy high for 200 cycles; done pulses once at cycle 200 after the start edge.
REQ-031 Mid-dump write: during the HEADER frame write r0=FF; during the r1 frame write r0=00 -> frame 2 carries FF, and r0 is not re-read.
REQ-032 Second start pulse at cycle 50 of a dump -> ignored; exactly 5 frames; a single done pulse.
REQ-033 reset pulse at cycle 90 -> tx=1 and busy=0 asynchronously; start at cycle 100 -> new dump begins with HEADER.
REQ-034 start tied high -> consecutive dumps separated by exactly one idle cycle (the done cycle); rd_addr is 0 at each HEADER.
REQ-035 CLKS_PER_BIT=2 with r0..r3 = 00,FF,55,AA -> correct bit timing; every start bit is exactly 2 cycles.
